// File: rtl/outbuf_fifo.sv
// outbuf_fifo: DEPTH-entry ring buffer between a compute core and a
// downstream consumer. It accepts one word per cycle and delivers one word
// per cycle. Cycles with cvalid low are not stored.
//
// cstop, ovalid and afull are decoded only from the level register, so no
// combinational path runs from ostop to cstop. When the buffer is full, a
// pop frees space, but the core cannot push until the following cycle. This
// costs one bubble per full-to-pop event.
//
// Parameters:
//   WIDTH  data width (signed, passed through bit-exact)
//   DEPTH  number of entries, power of two, >= 2
//   AFULL  occupancy at or above which afull asserts, 1..DEPTH
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (clears occupancy/pointers only)
//   cdata      core data in
//   cvalid     core data valid
//   cstop      stall to core: current cdata not accepted
//   odata      head-of-buffer data (don't-care while ovalid = 0)
//   ovalid     odata valid
//   ostop      downstream stall: odata not taken this cycle
//   level      occupancy 0..DEPTH
//   afull      level >= AFULL
//   stall_cnt  (only with OUTBUF_FIFO_STATS_EN) saturating count of
//              cycles with cvalid && cstop
//
// Optional feature macro: OUTBUF_FIFO_STATS_EN
module outbuf_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AFULL = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [WIDTH-1:0]      cdata,
  input  logic                         cvalid,
  output logic                         cstop,
  output logic signed [WIDTH-1:0]      odata,
  output logic                         ovalid,
  input  logic                         ostop,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         afull
`ifdef OUTBUF_FIFO_STATS_EN
  ,
  output logic [31:0]                  stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic signed [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic                    push;
  logic                    pop;

  // Full and empty come from level, never from comparing the pointers.
  assign cstop  = (level == LW'(DEPTH));
  assign ovalid = (level != '0);
  assign afull  = (level >= LW'(AFULL));

  assign push  = cvalid && !cstop;
  assign pop   = ovalid && !ostop;
  assign odata = mem[rd_ptr];

  // Control state: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      level  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage: not reset. After a reset, stale words are unreachable because
  // level returns to 0.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cdata;
  end

`ifdef OUTBUF_FIFO_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)                  stall_cnt <= '0;
    else if (cvalid && cstop) stall_cnt <= sat_inc(stall_cnt);
  end
`endif

endmodule
